// File: rtl/axis_loopback_tester_if.sv
// AXI-Stream bundle used for both the generated (tx) and returned (rx) streams.
// The master drives data/keep/last/valid; the slave drives ready.
interface axis_loopback_tester_if #(
   parameter int DATA_WIDTH = 64
);
   localparam int KB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] data;
   logic [KB-1:0]         keep;
   logic                  last;
   logic                  valid;
   logic                  ready;

   modport master (output data, keep, last, valid, input ready);
   modport slave  (input data, keep, last, valid, output ready);
endinterface

// File: rtl/axis_loopback_tester.sv
// AXI-Stream loopback traffic generator and byte-exact checker with programmable
// rx backpressure, drain timeout and pass/fail reporting.
module axis_loopback_tester #(
   parameter int DATA_WIDTH     = 64,
   parameter int LEN_WIDTH      = 16,
   parameter int CNT_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   input  logic [LEN_WIDTH-1:0] cfg_len,
   input  logic [CNT_WIDTH-1:0] cfg_num_pkts,
   input  logic [7:0]           cfg_rdy_mask,
   axis_loopback_tester_if.master tx,
   axis_loopback_tester_if.slave  rx,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 timeout,
   output logic [CNT_WIDTH-1:0] tx_pkts,
   output logic [CNT_WIDTH-1:0] rx_pkts,
   output logic [CNT_WIDTH-1:0] err_cnt,
   output logic [1:0]           dbg_state
);
   localparam int KB = DATA_WIDTH / 8;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]           KB_STEP  = 8'(KB % 256);
   localparam logic [LEN_WIDTH-1:0] KB_LEN   = LEN_WIDTH'(KB);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]           state;
   logic [2:0]           phase;
   logic [7:0]           mask_q;
   logic [CNT_WIDTH-1:0] num_q;
   logic [LEN_WIDTH-1:0] last_beat_q;
   logic [KB-1:0]        last_keep_q;
   logic [LEN_WIDTH-1:0] tx_beat, rx_beat;
   logic [7:0]           tx_base, rx_base;
   logic                 stop_pend;
   logic [TW-1:0]        tmo_cnt;

   // Config decode: packet geometry is fixed at start so the datapath only compares indices.
   logic [LEN_WIDTH-1:0] eff_len, cfg_last_beat, cfg_rem;
   logic [KB-1:0]        cfg_last_keep;
   always_comb begin
      eff_len       = (cfg_len == '0) ? LEN_ONE : cfg_len;
      cfg_last_beat = (eff_len - LEN_ONE) / KB_LEN;
      cfg_rem       = eff_len % KB_LEN;
      cfg_last_keep = '0;
      for (int i = 0; i < KB; i++)
         cfg_last_keep[i] = (cfg_rem == '0) || (LEN_WIDTH'(i) < cfg_rem);
   end

   // Handshake: a beat transfers on a cycle where valid and ready are both high at the
   // rising edge; the master holds data/keep/last stable while valid is high and ready low.
   logic run, active, tx_is_last, tx_hs, rx_rdy, rx_hs;
   always_comb begin
      run        = (state == RUN);
      active     = (state == RUN) || (state == DRAIN);
      tx_is_last = (tx_beat == last_beat_q);
      tx.valid   = run;
      tx.last    = run && tx_is_last;
      tx.keep    = !run ? '0 : (tx_is_last ? last_keep_q : '1);
      tx.data    = '0;
      for (int i = 0; i < KB; i++)
         tx.data[8*i +: 8] = run ? (tx_base + 8'(i)) : 8'h00;
      tx_hs      = run && tx.ready;
   end

   always_comb begin
      rx_rdy   = active ? mask_q[phase] : (state == DONE);
      rx.ready = rx_rdy;
      rx_hs    = active && rx.valid && rx_rdy;
   end

   // Checker: the expected position is tracked independently of the generator.
   logic                 exp_last, beat_err;
   logic [KB-1:0]        exp_keep;
   logic [CNT_WIDTH-1:0] rx_pkts_nx, err_nx;
   always_comb begin
      exp_last = (rx_beat == last_beat_q);
      exp_keep = exp_last ? last_keep_q : '1;
      beat_err = (rx.keep != exp_keep) || (rx.last != exp_last);
      for (int i = 0; i < KB; i++)
         if (exp_keep[i] && (rx.data[8*i +: 8] != rx_base + 8'(i)))
            beat_err = 1'b1;
      rx_pkts_nx = (rx_hs && rx.last) ? rx_pkts + CNT_ONE : rx_pkts;
      err_nx     = (rx_hs && beat_err && (err_cnt != '1)) ? err_cnt + CNT_ONE : err_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         phase       <= '0;
         mask_q      <= '0;
         num_q       <= '0;
         last_beat_q <= '0;
         last_keep_q <= '0;
         tx_beat     <= '0;
         rx_beat     <= '0;
         tx_base     <= '0;
         rx_base     <= '0;
         stop_pend   <= 1'b0;
         tmo_cnt     <= '0;
         tx_pkts     <= '0;
         rx_pkts     <= '0;
         err_cnt     <= '0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         if (active) begin
            phase <= phase + 3'd1;
            if (rx_hs) begin
               rx_pkts <= rx_pkts_nx;
               err_cnt <= err_nx;
               // A mismatching beat never desynchronises the checker: rx_last always realigns it.
               if (rx.last) begin
                  rx_beat <= '0;
                  rx_base <= rx_pkts[7:0] + 8'd1;
               end else begin
                  rx_beat <= rx_beat + LEN_ONE;
                  rx_base <= rx_base + KB_STEP;
               end
            end
         end

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= RUN;
                  phase       <= '0;
                  mask_q      <= cfg_rdy_mask;
                  num_q       <= cfg_num_pkts;
                  last_beat_q <= cfg_last_beat;
                  last_keep_q <= cfg_last_keep;
                  tx_beat     <= '0;
                  rx_beat     <= '0;
                  tx_base     <= '0;
                  rx_base     <= '0;
                  stop_pend   <= 1'b0;
                  tmo_cnt     <= '0;
                  tx_pkts     <= '0;
                  rx_pkts     <= '0;
                  err_cnt     <= '0;
                  pass        <= 1'b0;
                  timeout     <= 1'b0;
               end
            end
            RUN: begin
               tmo_cnt <= '0;
               if (stop) stop_pend <= 1'b1;
               if (tx_hs) begin
                  if (tx_is_last) begin
                     tx_pkts <= tx_pkts + CNT_ONE;
                     tx_beat <= '0;
                     tx_base <= tx_pkts[7:0] + 8'd1;
                     if (((num_q != '0) && (tx_pkts + CNT_ONE == num_q)) || stop_pend || stop)
                        state <= DRAIN;
                  end else begin
                     tx_beat <= tx_beat + LEN_ONE;
                     tx_base <= tx_base + KB_STEP;
                  end
               end
            end
            DRAIN: begin
               if (rx_pkts_nx == tx_pkts) begin
                  state <= DONE;
                  pass  <= (err_nx == '0);
               end else if (rx_hs) begin
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  state   <= DONE;
                  timeout <= 1'b1;
                  pass    <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = active;
   assign done      = (state == DONE);
   assign dbg_state = state;
endmodule

// File: tb/tb_axis_loopback_tester.sv
// Bench for axis_loopback_tester: a configurable loopback (ideal, corrupting, dropping) around
// a 64-bit instance plus an ideal loopback around a 256-bit instance, checked against a packet model.
module tb_axis_loopback_tester;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, stop, start256;
   logic [15:0] cfg_len;
   logic [31:0] cfg_num_pkts;
   logic [7:0]  cfg_rdy_mask;

   axis_loopback_tester_if #(.DATA_WIDTH(64))  tx64 ();
   axis_loopback_tester_if #(.DATA_WIDTH(64))  rx64 ();
   axis_loopback_tester_if #(.DATA_WIDTH(256)) tx256 ();
   axis_loopback_tester_if #(.DATA_WIDTH(256)) rx256 ();

   logic        busy64, done64, pass64, timeout64, busy256, done256, pass256, timeout256;
   logic [31:0] tx_pkts64, rx_pkts64, err64, tx_pkts256, rx_pkts256, err256;
   logic [1:0]  dbg64, dbg256;

   axis_loopback_tester #(.DATA_WIDTH(64)) dut64 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_len(cfg_len),
      .cfg_num_pkts(cfg_num_pkts), .cfg_rdy_mask(cfg_rdy_mask), .tx(tx64), .rx(rx64),
      .busy(busy64), .done(done64), .pass(pass64), .timeout(timeout64), .tx_pkts(tx_pkts64),
      .rx_pkts(rx_pkts64), .err_cnt(err64), .dbg_state(dbg64));

   axis_loopback_tester #(.DATA_WIDTH(256)) dut256 (
      .clk(clk), .reset(reset), .start(start256), .stop(1'b0), .cfg_len(cfg_len),
      .cfg_num_pkts(cfg_num_pkts), .cfg_rdy_mask(cfg_rdy_mask), .tx(tx256), .rx(rx256),
      .busy(busy256), .done(done256), .pass(pass256), .timeout(timeout256), .tx_pkts(tx_pkts256),
      .rx_pkts(rx_pkts256), .err_cnt(err256), .dbg_state(dbg256));

   int checks = 0;
   int passes = 0;

   // Loopback model: 0 ideal, 1 flips byte 3 of beat 1 of packet 0, 2 swallows packet 1.
   int mode = 0;
   int gate_pct = 100;
   bit gate = 1'b1;
   int trk_pkt = 0, trk_beat = 0;
   logic drop_now, corrupt_now;

   always @(posedge clk) begin
      #1;
      gate = ($urandom_range(0, 99) < gate_pct);
   end

   always @(posedge clk) begin
      if (reset || start) begin
         trk_pkt  <= 0;
         trk_beat <= 0;
      end else if (tx64.valid && tx64.ready) begin
         if (tx64.last) begin
            trk_pkt  <= trk_pkt + 1;
            trk_beat <= 0;
         end else begin
            trk_beat <= trk_beat + 1;
         end
      end
   end

   assign drop_now    = (mode == 2) && (trk_pkt == 1);
   assign corrupt_now = (mode == 1) && (trk_pkt == 0) && (trk_beat == 1);
   assign rx64.data   = tx64.data ^ (corrupt_now ? 64'h0000_0000_FF00_0000 : 64'h0);
   assign rx64.keep   = tx64.keep;
   assign rx64.last   = tx64.last;
   assign rx64.valid  = tx64.valid && gate && !drop_now;
   assign tx64.ready  = drop_now ? gate : (rx64.ready && gate);

   assign rx256.data  = tx256.data;
   assign rx256.keep  = tx256.keep;
   assign rx256.last  = tx256.last;
   assign rx256.valid = tx256.valid;
   assign tx256.ready = rx256.ready;

   // Reference packet model: {last, keep[31:0], data[255:0]} for beat b of packet p.
   function automatic int model_beats(input int kb, input int len);
      int l;
      l = (len == 0) ? 1 : len;
      return (l + kb - 1) / kb;
   endfunction

   function automatic logic [288:0] model_beat(input int kb, input int p, input int b, input int len);
      logic [288:0] m;
      int l, nb, rem;
      m   = '0;
      l   = (len == 0) ? 1 : len;
      nb  = model_beats(kb, len);
      rem = l % kb;
      for (int i = 0; i < kb; i++) begin
         m[8*i +: 8] = 8'((p + b * kb + i) % 256);
         if (b != nb - 1 || rem == 0 || i < rem) m[256 + i] = 1'b1;
      end
      m[288] = (b == nb - 1);
      return m;
   endfunction

   logic [72:0]  exp64_q[$];
   logic [288:0] exp256_q[$];
   bit chk_rdy = 1'b0;
   int run_cyc = 0;
   int drain_cyc = 0;

   // Scoreboard: every presented tx beat (stalled or not) must equal the head of the expected queue.
   always @(negedge clk) begin
      if (tx64.valid) begin
         if (exp64_q.size() == 0) begin
            if (tx64.ready) begin
               checks++;
               $display("FAIL tx64_unexpected_beat actual=%h expected=none", tx64.data);
            end
         end else begin
            checks++;
            if ({tx64.last, tx64.keep, tx64.data} !== exp64_q[0])
               $display("FAIL tx64_beat actual=%h expected=%h", {tx64.last, tx64.keep, tx64.data}, exp64_q[0]);
            else passes++;
            if (tx64.ready) void'(exp64_q.pop_front());
         end
      end
      if (chk_rdy && busy64) begin
         checks++;
         if (rx64.ready !== cfg_rdy_mask[run_cyc % 8])
            $display("FAIL rx_ready_pattern cycle=%0d actual=%b expected=%b", run_cyc, rx64.ready, cfg_rdy_mask[run_cyc % 8]);
         else passes++;
         run_cyc++;
      end
      if (busy64 && !tx64.valid) drain_cyc++;
      if (tx256.valid) begin
         if (exp256_q.size() == 0) begin
            if (tx256.ready) begin
               checks++;
               $display("FAIL tx256_unexpected_beat actual=%h expected=none", tx256.keep);
            end
         end else begin
            checks++;
            if ({tx256.last, tx256.keep, tx256.data} !== exp256_q[0])
               $display("FAIL tx256_beat actual=%h expected=%h", {tx256.last, tx256.keep, tx256.data}, exp256_q[0]);
            else passes++;
            if (tx256.ready) void'(exp256_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic start_run(input int len, input int num, input logic [7:0] mask, input int npush);
      logic [288:0] m;
      cfg_len      = 16'(len);
      cfg_num_pkts = 32'(num);
      cfg_rdy_mask = mask;
      exp64_q.delete();
      for (int p = 0; p < npush; p++)
         for (int b = 0; b < model_beats(8, len); b++) begin
            m = model_beat(8, p, b, len);
            exp64_q.push_back({m[288], m[263:256], m[63:0]});
         end
      run_cyc   = 0;
      drain_cyc = 0;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done64) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if ({tx64.valid, rx64.ready, busy64, done64, pass64, timeout64, dbg64} !== 8'h00)
         $display("FAIL reset_flags actual=%b expected=0", {tx64.valid, rx64.ready, busy64, done64, pass64, timeout64, dbg64});
      else passes++;
      checks++;
      if ({tx_pkts64, rx_pkts64, err64} !== 96'h0)
         $display("FAIL reset_counters actual=%0d/%0d/%0d expected=0/0/0", tx_pkts64, rx_pkts64, err64);
      else passes++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      bit ok;
      mode = 0; gate_pct = 100;
      start_run(20, 3, 8'hFF, 3);
      wait_done(2000, ok);
      checks++; if (!ok) $display("FAIL basic_done actual=0 expected=1"); else passes++;
      checks++;
      if ({tx_pkts64, rx_pkts64, err64} !== {32'd3, 32'd3, 32'd0})
         $display("FAIL basic_counts actual=%0d/%0d/%0d expected=3/3/0", tx_pkts64, rx_pkts64, err64);
      else passes++;
      checks++;
      if ({pass64, timeout64, busy64} !== 3'b100)
         $display("FAIL basic_flags actual=%b expected=100", {pass64, timeout64, busy64});
      else passes++;
      checks++;
      if (exp64_q.size() != 0) $display("FAIL basic_beats_left actual=%0d expected=0", exp64_q.size()); else passes++;
   endtask

   task automatic test_backpressure();
      bit ok;
      int len, n;
      len = $urandom_range(1, 40);
      n   = $urandom_range(2, 5);
      mode = 0; gate_pct = 50; chk_rdy = 1'b1;
      start_run(len, n, 8'hA5, n);
      wait_done(20000, ok);
      chk_rdy = 1'b0; gate_pct = 100;
      checks++; if (!ok) $display("FAIL bp_done actual=0 expected=1"); else passes++;
      checks++;
      if ({tx_pkts64, rx_pkts64, err64} !== {32'(n), 32'(n), 32'd0})
         $display("FAIL bp_counts actual=%0d/%0d/%0d expected=%0d/%0d/0", tx_pkts64, rx_pkts64, err64, n, n);
      else passes++;
      checks++;
      if ({pass64, timeout64} !== 2'b10) $display("FAIL bp_flags actual=%b expected=10", {pass64, timeout64}); else passes++;
   endtask

   task automatic test_corrupt();
      bit ok;
      mode = 1;
      start_run(64, 3, 8'hFF, 3);
      wait_done(2000, ok);
      mode = 0;
      checks++; if (!ok) $display("FAIL corrupt_done actual=0 expected=1"); else passes++;
      checks++;
      if ({tx_pkts64, rx_pkts64, err64} !== {32'd3, 32'd3, 32'd1})
         $display("FAIL corrupt_counts actual=%0d/%0d/%0d expected=3/3/1", tx_pkts64, rx_pkts64, err64);
      else passes++;
      checks++;
      if ({pass64, timeout64} !== 2'b00) $display("FAIL corrupt_flags actual=%b expected=00", {pass64, timeout64}); else passes++;
   endtask

   task automatic test_drop();
      bit ok;
      int len, exp_err;
      int got[3];
      len = $urandom_range(1, 40);
      got = '{0, 2, 3};
      exp_err = 0;
      // Packets 2 and 3 arrive where 1 and 2 are expected: every beat of them mismatches.
      for (int k = 0; k < 3; k++) if (got[k] != k) exp_err += model_beats(8, len);
      mode = 2;
      start_run(len, 4, 8'hFF, 4);
      wait_done(6000, ok);
      mode = 0;
      checks++; if (!ok) $display("FAIL drop_done actual=0 expected=1"); else passes++;
      checks++;
      if ({tx_pkts64, rx_pkts64, err64} !== {32'd4, 32'd3, 32'(exp_err)})
         $display("FAIL drop_counts actual=%0d/%0d/%0d expected=4/3/%0d", tx_pkts64, rx_pkts64, err64, exp_err);
      else passes++;
      checks++;
      if ({pass64, timeout64} !== 2'b01) $display("FAIL drop_flags actual=%b expected=01", {pass64, timeout64}); else passes++;
      checks++;
      if (drain_cyc != 4096) $display("FAIL drop_drain_cycles actual=%0d expected=4096", drain_cyc); else passes++;
   endtask

   task automatic test_stop();
      bit ok, hit;
      mode = 0;
      start_run(40, 0, 8'hFF, 6);
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
         if (trk_pkt == 5 && trk_beat == 2) hit = 1'b1;
         else step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++; if (!hit) $display("FAIL stop_reach_beat actual=%0d.%0d expected=5.2", trk_pkt, trk_beat); else passes++;
      wait_done(2000, ok);
      checks++; if (!ok) $display("FAIL stop_done actual=0 expected=1"); else passes++;
      checks++;
      if ({tx_pkts64, rx_pkts64, err64, pass64} !== {32'd6, 32'd6, 32'd0, 1'b1})
         $display("FAIL stop_result actual=%0d/%0d/%0d/%b expected=6/6/0/1", tx_pkts64, rx_pkts64, err64, pass64);
      else passes++;
      checks++;
      if (exp64_q.size() != 0) $display("FAIL stop_beats_left actual=%0d expected=0", exp64_q.size()); else passes++;
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      start_run(20, 0, 8'hFF, 20);
      repeat (10) step();
      checks++; if (tx64.valid !== 1'b1) $display("FAIL midrun_valid actual=%b expected=1", tx64.valid); else passes++;
      reset = 1'b1;
      step();
      checks++;
      if ({tx64.valid, tx64.last, tx64.keep, rx64.ready, busy64, done64, pass64, timeout64, dbg64} !== 16'h0)
         $display("FAIL midrun_reset_flags actual=%h expected=0",
                  {tx64.valid, tx64.last, tx64.keep, rx64.ready, busy64, done64, pass64, timeout64, dbg64});
      else passes++;
      checks++;
      if ({tx_pkts64, rx_pkts64, err64} !== 96'h0)
         $display("FAIL midrun_reset_counters actual=%0d/%0d/%0d expected=0/0/0", tx_pkts64, rx_pkts64, err64);
      else passes++;
      reset = 1'b0;
      exp64_q.delete();
      step();
      start_run(20, 3, 8'hFF, 3);
      wait_done(2000, ok);
      checks++;
      if (!ok || {tx_pkts64, rx_pkts64, err64, pass64} !== {32'd3, 32'd3, 32'd0, 1'b1})
         $display("FAIL midrun_rerun actual=%0d/%0d/%0d/%b expected=3/3/0/1", tx_pkts64, rx_pkts64, err64, pass64);
      else passes++;
   endtask

   task automatic test_wide();
      bit ok;
      cfg_len = 16'd20; cfg_num_pkts = 32'd3; cfg_rdy_mask = 8'hFF;
      exp256_q.delete();
      for (int p = 0; p < 3; p++)
         for (int b = 0; b < model_beats(32, 20); b++) exp256_q.push_back(model_beat(32, p, b, 20));
      start256 = 1'b1;
      step();
      start256 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (done256) ok = 1'b1;
         else step();
      end
      checks++; if (!ok) $display("FAIL wide_done actual=0 expected=1"); else passes++;
      checks++;
      if ({tx_pkts256, rx_pkts256, err256, pass256, timeout256} !== {32'd3, 32'd3, 32'd0, 2'b10})
         $display("FAIL wide_result actual=%0d/%0d/%0d/%b%b expected=3/3/0/10",
                  tx_pkts256, rx_pkts256, err256, pass256, timeout256);
      else passes++;
      checks++;
      if (exp256_q.size() != 0) $display("FAIL wide_beats_left actual=%0d expected=0", exp256_q.size()); else passes++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; start256 = 1'b0;
      cfg_len = 16'd0; cfg_num_pkts = 32'd0; cfg_rdy_mask = 8'h00;
      test_reset();
      test_basic();
      test_backpressure();
      test_corrupt();
      test_drop();
      test_stop();
      test_reset_mid_run();
      test_wide();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
